// File: rtl/rv32i_control.sv
// Multicycle Moore control FSM for the mp1 RV32I core.
// Sequences fetch/decode/execute/writeback and drives every datapath load
// enable, mux select, ALU/CMP op and the memory request handshake.
// Optional: define RV32I_CONTROL_ILLEGAL_TRAP_EN to trap unsupported opcodes
// in a HALT state (illegal_op=1) that only rst can leave.
module rv32i_control #(
   parameter logic [3:0] MEM_BE_WORD = 4'b1111
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       br_en,
   input  logic       mem_resp,
   output logic       load_pc,
   output logic       load_ir,
   output logic       load_regfile,
   output logic       load_mar,
   output logic       load_mdr,
   output logic       load_data_out,
   output logic       pcmux_sel,
   output logic       alumux1_sel,
   output logic [1:0] alumux2_sel,
   output logic [1:0] regfilemux_sel,
   output logic       marmux_sel,
   output logic       cmpmux_sel,
   output logic [2:0] aluop,
   output logic [2:0] cmpop,
   output logic       mem_read,
   output logic       mem_write,
   output logic [3:0] mem_byte_enable,
   output logic       illegal_op
);

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SRA = 3'b010;
   localparam logic [2:0] ALU_SRL = 3'b101;

   localparam logic [2:0] CMP_BEQ  = 3'b000;
   localparam logic [2:0] CMP_BLT  = 3'b100;
   localparam logic [2:0] CMP_BLTU = 3'b110;

   typedef enum logic [3:0] {
      StFetch1, StFetch2, StFetch3, StDecode,
      StLui, StAuipc, StBr, StImm,
      StCalcAddr, StLd1, StLd2, StSt1, StSt2
`ifdef RV32I_CONTROL_ILLEGAL_TRAP_EN
      , StHalt
`endif
   } state_t;

   state_t state_q, state_d;

   // Only funct7[5] (sra vs srl) matters to this FSM.
   logic unused_funct7;
   assign unused_funct7 = ^{funct7[6], funct7[4:0]};

   assign mem_byte_enable = MEM_BE_WORD;

   // State register; rst wins over any pending memory wait.
   always_ff @(posedge clk) begin
      if (rst) state_q <= StFetch1;
      else     state_q <= state_d;
   end

   // Next-state and Moore outputs (plus the IR-field/br_en dependent selects).
   always_comb begin
      state_d        = state_q;
      load_pc        = 1'b0;
      load_ir        = 1'b0;
      load_regfile   = 1'b0;
      load_mar       = 1'b0;
      load_mdr       = 1'b0;
      load_data_out  = 1'b0;
      pcmux_sel      = 1'b0;
      alumux1_sel    = 1'b0;
      alumux2_sel    = 2'd0;
      regfilemux_sel = 2'd0;
      marmux_sel     = 1'b0;
      cmpmux_sel     = 1'b0;
      aluop          = ALU_ADD;
      cmpop          = CMP_BEQ;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      illegal_op     = 1'b0;

      case (state_q)
         StFetch1: begin
            load_mar = 1'b1;
            state_d  = StFetch2;
         end
         StFetch2: begin
            mem_read = 1'b1;
            load_mdr = 1'b1;
            if (mem_resp) state_d = StFetch3;
         end
         StFetch3: begin
            load_ir = 1'b1;
            state_d = StDecode;
         end
         StDecode: begin
            case (opcode)
               OP_LUI:             state_d = StLui;
               OP_AUIPC:           state_d = StAuipc;
               OP_BR:              state_d = StBr;
               OP_LOAD, OP_STORE:  state_d = StCalcAddr;
               OP_IMM:             state_d = StImm;
`ifdef RV32I_CONTROL_ILLEGAL_TRAP_EN
               default:            state_d = StHalt;
`else
               default:            state_d = StFetch1;
`endif
            endcase
         end
         StLui: begin
            regfilemux_sel = 2'd2;
            load_regfile   = 1'b1;
            load_pc        = 1'b1;
            state_d        = StFetch1;
         end
         StAuipc: begin
            alumux1_sel  = 1'b1;
            alumux2_sel  = 2'd1;
            load_regfile = 1'b1;
            load_pc      = 1'b1;
            state_d      = StFetch1;
         end
         StBr: begin
            cmpop       = funct3;
            alumux1_sel = 1'b1;
            alumux2_sel = 2'd2;
            pcmux_sel   = br_en;
            load_pc     = 1'b1;
            state_d     = StFetch1;
         end
         StImm: begin
            load_regfile = 1'b1;
            load_pc      = 1'b1;
            case (funct3)
               3'b010: begin
                  cmpmux_sel     = 1'b1;
                  cmpop          = CMP_BLT;
                  regfilemux_sel = 2'd1;
               end
               3'b011: begin
                  cmpmux_sel     = 1'b1;
                  cmpop          = CMP_BLTU;
                  regfilemux_sel = 2'd1;
               end
               3'b101:  aluop = funct7[5] ? ALU_SRA : ALU_SRL;
               // add/sll/xor/or/and share their funct3 encoding with aluop.
               default: aluop = funct3;
            endcase
            state_d = StFetch1;
         end
         StCalcAddr: begin
            marmux_sel = 1'b1;
            load_mar   = 1'b1;
            if (opcode == OP_STORE) begin
               alumux2_sel   = 2'd3;
               load_data_out = 1'b1;
               state_d       = StSt1;
            end else begin
               state_d = StLd1;
            end
         end
         StLd1: begin
            mem_read = 1'b1;
            load_mdr = 1'b1;
            if (mem_resp) state_d = StLd2;
         end
         StLd2: begin
            regfilemux_sel = 2'd3;
            load_regfile   = 1'b1;
            load_pc        = 1'b1;
            state_d        = StFetch1;
         end
         StSt1: begin
            mem_write = 1'b1;
            if (mem_resp) state_d = StSt2;
         end
         StSt2: begin
            load_pc = 1'b1;
            state_d = StFetch1;
         end
`ifdef RV32I_CONTROL_ILLEGAL_TRAP_EN
         StHalt: begin
            illegal_op = 1'b1;
         end
`endif
         default: state_d = StFetch1;
      endcase
   end

endmodule

// File: tb/tb_rv32i_control.sv
// Scoreboard bench for rv32i_control: expected control vectors are queued as
// each cycle's stimulus is driven and compared when the outputs settle.
module tb_rv32i_control;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       br_en;
   logic       mem_resp;
   logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
   logic       pcmux_sel, alumux1_sel, marmux_sel, cmpmux_sel;
   logic [1:0] alumux2_sel, regfilemux_sel;
   logic [2:0] aluop, cmpop;
   logic       mem_read, mem_write, illegal_op;
   logic [3:0] mem_byte_enable;

   typedef struct packed {
      logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
      logic       pcmux, alumux1;
      logic [1:0] alumux2, regfilemux;
      logic       marmux, cmpmux;
      logic [2:0] aluop, cmpop;
      logic       mem_read, mem_write;
      logic [3:0] be;
      logic       illegal;
   } ctl_t;

   typedef struct {
      string tag;
      ctl_t  exp;
   } sb_t;

   sb_t  sb_q[$];
   ctl_t obs;
   int   n_checks = 0;
   int   n_pass   = 0;

   rv32i_control dut (
      .clk            (clk),
      .rst            (rst),
      .opcode         (opcode),
      .funct3         (funct3),
      .funct7         (funct7),
      .br_en          (br_en),
      .mem_resp       (mem_resp),
      .load_pc        (load_pc),
      .load_ir        (load_ir),
      .load_regfile   (load_regfile),
      .load_mar       (load_mar),
      .load_mdr       (load_mdr),
      .load_data_out  (load_data_out),
      .pcmux_sel      (pcmux_sel),
      .alumux1_sel    (alumux1_sel),
      .alumux2_sel    (alumux2_sel),
      .regfilemux_sel (regfilemux_sel),
      .marmux_sel     (marmux_sel),
      .cmpmux_sel     (cmpmux_sel),
      .aluop          (aluop),
      .cmpop          (cmpop),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_byte_enable(mem_byte_enable),
      .illegal_op     (illegal_op)
   );

   always #5 clk = ~clk;

   assign obs = {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out,
                 pcmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel, marmux_sel,
                 cmpmux_sel, aluop, cmpop, mem_read, mem_write, mem_byte_enable,
                 illegal_op};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, want);
   endtask

   function automatic ctl_t dflt();
      ctl_t c;
      c    = '0;
      c.be = 4'b1111;
      return c;
   endfunction

   // Queue the expectation for the cycle whose inputs were just driven,
   // compare mid-cycle, then advance past the next active edge.
   task automatic cyc(input string tag, input ctl_t e);
      sb_t item;
      sb_q.push_back('{tag: tag, exp: e});
      @(negedge clk);
      item = sb_q.pop_front();
      check(item.tag, {5'b0, obs}, {5'b0, item.exp});
      @(posedge clk);
      #1;
   endtask

   // Memory wait state: response arrives in cycle n of the wait.
   task automatic mem_wait(input string tag, input int n, input ctl_t e);
      for (int i = 0; i < n; i++) begin
         mem_resp = (i == n - 1);
         cyc(tag, e);
      end
      mem_resp = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] ir, input int n_wait);
      ctl_t e;
      opcode   = ir[6:0];
      funct3   = ir[14:12];
      funct7   = ir[31:25];
      mem_resp = 1'b0;
      e = dflt(); e.load_mar = 1'b1;
      cyc("fetch1", e);
      e = dflt(); e.mem_read = 1'b1; e.load_mdr = 1'b1;
      mem_wait("fetch2", n_wait, e);
      e = dflt(); e.load_ir = 1'b1;
      cyc("fetch3", e);
      cyc("decode", dflt());
   endtask

   task automatic imm_case(input string tag, input logic [31:0] ir, input logic [2:0] aop,
                           input logic cmux, input logic [2:0] cop, input logic [1:0] rmux);
      ctl_t e;
      fetch(ir, 1);
      e = dflt();
      e.load_regfile = 1'b1; e.load_pc = 1'b1;
      e.aluop = aop; e.cmpmux = cmux; e.cmpop = cop; e.regfilemux = rmux;
      cyc(tag, e);
   endtask

   task automatic br_case(input string tag, input logic [31:0] ir, input logic taken,
                          input logic [2:0] cop);
      ctl_t e;
      fetch(ir, 2);
      br_en = taken;
      e = dflt();
      e.load_pc = 1'b1; e.pcmux = taken; e.alumux1 = 1'b1; e.alumux2 = 2'd2; e.cmpop = cop;
      cyc(tag, e);
      br_en = 1'b0;
   endtask

   initial begin
      ctl_t e;
      rst = 1'b1; opcode = '0; funct3 = '0; funct7 = '0; br_en = 1'b0; mem_resp = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      e = dflt(); e.load_mar = 1'b1;
      cyc("reset_fetch1", e);
      rst = 1'b0;

      // First fetch with a 3-cycle memory wait, then addi.
      fetch(32'h0050_0093, 3);
      e = dflt(); e.load_regfile = 1'b1; e.load_pc = 1'b1;
      cyc("addi", e);

      imm_case("srai", 32'h4030_D113, 3'b010, 1'b0, 3'b000, 2'd0);
      imm_case("srli", 32'h0020_D093, 3'b101, 1'b0, 3'b000, 2'd0);
      imm_case("slti", 32'h0070_A193, 3'b000, 1'b1, 3'b100, 2'd1);
      imm_case("sltiu", 32'h0070_B193, 3'b000, 1'b1, 3'b110, 2'd1);
      imm_case("andi", 32'h0FF0_F093, 3'b111, 1'b0, 3'b000, 2'd0);
      imm_case("xori", 32'h0010_C093, 3'b100, 1'b0, 3'b000, 2'd0);

      br_case("beq_taken", 32'h0000_0463, 1'b1, 3'b000);
      br_case("beq_not_taken", 32'h0000_0463, 1'b0, 3'b000);
      br_case("bltu_taken", 32'h0020_E463, 1'b1, 3'b110);

      fetch(32'h1234_50B7, 1);
      e = dflt(); e.regfilemux = 2'd2; e.load_regfile = 1'b1; e.load_pc = 1'b1;
      cyc("lui", e);

      fetch(32'h0000_1117, 1);
      e = dflt(); e.alumux1 = 1'b1; e.alumux2 = 2'd1; e.load_regfile = 1'b1; e.load_pc = 1'b1;
      cyc("auipc", e);

      // sw x1,4(x0)
      fetch(32'h0010_2223, 2);
      e = dflt(); e.alumux2 = 2'd3; e.marmux = 1'b1; e.load_mar = 1'b1; e.load_data_out = 1'b1;
      cyc("sw_calc", e);
      e = dflt(); e.mem_write = 1'b1;
      mem_wait("sw_st1", 3, e);
      e = dflt(); e.load_pc = 1'b1;
      cyc("sw_st2", e);

      // lw x3,4(x0)
      fetch(32'h0040_2183, 1);
      e = dflt(); e.marmux = 1'b1; e.load_mar = 1'b1;
      cyc("lw_calc", e);
      e = dflt(); e.mem_read = 1'b1; e.load_mdr = 1'b1;
      mem_wait("lw_ld1", 2, e);
      e = dflt(); e.regfilemux = 2'd3; e.load_regfile = 1'b1; e.load_pc = 1'b1;
      cyc("lw_ld2", e);

      // Unsupported opcode 0x7F.
      fetch(32'h0000_007F, 1);
`ifdef RV32I_CONTROL_ILLEGAL_TRAP_EN
      e = dflt(); e.illegal = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mem_resp = i[0];
         cyc("halt_hold", e);
      end
      mem_resp = 1'b0;
`else
      e = dflt(); e.load_mar = 1'b1;
`endif
      rst = 1'b1;
      cyc("illegal_then_rst", e);
      rst = 1'b0;

      // Reset while waiting on a load response.
      fetch(32'h0040_2183, 1);
      e = dflt(); e.marmux = 1'b1; e.load_mar = 1'b1;
      cyc("lw2_calc", e);
      e = dflt(); e.mem_read = 1'b1; e.load_mdr = 1'b1;
      cyc("lw2_ld1_wait", e);
      rst = 1'b1;
      cyc("lw2_ld1_rst", e);
      rst = 1'b0;

      // fetch() opens with FETCH1: mem_read must already be low.
      fetch(32'h0050_0093, 2);
      e = dflt(); e.load_regfile = 1'b1; e.load_pc = 1'b1;
      cyc("addi_after_rst", e);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
